// File: rtl/norm_share_ctrl_if.sv
// Bundle for the shared-normalizer controller: two requesters, the normalizer hookup
// and the response channel. slave = controller side, master = environment side.
interface norm_share_ctrl_if;
  logic        a_valid;
  logic        a_ready;
  logic [52:0] a_res53;
  logic [10:0] a_exp;

  logic        b_valid;
  logic        b_ready;
  logic [52:0] b_res53;
  logic [7:0]  b_exp_hi;
  logic [7:0]  b_exp_lo;

  // nrm_op53 feeds the normalizer; nrm_res53 is what comes back from it
  logic        nrm_mode;
  logic [52:0] nrm_op53;
  logic [4:0]  nrm_z24;
  logic [4:0]  nrm_z29;
  logic [5:0]  nrm_z52;
  logic [52:0] nrm_res53;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [52:0] rsp_res53;
  logic [10:0] rsp_exp_hi;
  logic [7:0]  rsp_exp_lo;
  logic [1:0]  rsp_zero;
  logic [1:0]  rsp_uflow;
  logic        busy;

  modport slave (
    input  a_valid, a_res53, a_exp,
    input  b_valid, b_res53, b_exp_hi, b_exp_lo,
    input  nrm_z24, nrm_z29, nrm_z52, nrm_res53,
    input  rsp_ready,
    output a_ready, b_ready,
    output nrm_mode, nrm_op53,
    output rsp_valid, rsp_id, rsp_res53, rsp_exp_hi, rsp_exp_lo, rsp_zero, rsp_uflow,
    output busy
  );

  modport master (
    output a_valid, a_res53, a_exp,
    output b_valid, b_res53, b_exp_hi, b_exp_lo,
    output nrm_z24, nrm_z29, nrm_z52, nrm_res53,
    output rsp_ready,
    input  a_ready, b_ready,
    input  nrm_mode, nrm_op53,
    input  rsp_valid, rsp_id, rsp_res53, rsp_exp_hi, rsp_exp_lo, rsp_zero, rsp_uflow,
    input  busy
  );
endinterface

// File: rtl/norm_share_ctrl.sv
// Arbitrates the dual-mode FP adder's shared leading-zero normalizer between a double
// requester (A) and a packed dual-single requester (B); one operation in flight at a time.
module norm_share_ctrl #(
  parameter int unsigned NRM_LAT = 1,
  parameter bit          RR_EN   = 1'b1
) (
  input logic              i_clk,
  input logic              i_rst,
  norm_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        pref_b;
  logic [10:0] op_exp_hi;
  logic [7:0]  op_exp_lo;

  logic        grant_b;
  logic        a_rdy, b_rdy;
  logic        acc, cap;

  logic [12:0] dbl_adj;
  logic [9:0]  hi_adj, lo_adj;

  // Result packed as {zero, uflow, exponent}; a zero mantissa overrides underflow.
  function automatic logic [12:0] exp_adj_dbl(input logic [10:0] e, input logic [5:0] s,
                                               input logic z);
    logic signed [12:0] d;
    d = $signed({2'b00, e}) - $signed({7'b0, s});
    if (z)
      exp_adj_dbl = {1'b1, 1'b0, 11'd0};
    else if (d <= 13'sd0)
      exp_adj_dbl = {1'b0, 1'b1, 11'd0};
    else
      exp_adj_dbl = {1'b0, 1'b0, d[10:0]};
  endfunction

  function automatic logic [9:0] exp_adj_sgl(input logic [7:0] e, input logic [4:0] s,
                                             input logic z);
    logic signed [9:0] d;
    d = $signed({2'b00, e}) - $signed({5'b0, s});
    if (z)
      exp_adj_sgl = {1'b1, 1'b0, 8'd0};
    else if (d <= 10'sd0)
      exp_adj_sgl = {1'b0, 1'b1, 8'd0};
    else
      exp_adj_sgl = {1'b0, 1'b0, d[7:0]};
  endfunction

  assign grant_b = bus.b_valid & (~bus.a_valid | (RR_EN & pref_b));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Readies are gated by reset so nothing is offered while the block is held.
  always_comb begin
    state_nxt = state;
    a_rdy     = 1'b0;
    b_rdy     = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (!i_rst) begin
          a_rdy = bus.a_valid & ~grant_b;
          b_rdy = grant_b;
          if (bus.a_valid | bus.b_valid) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          cap       = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign acc         = a_rdy | b_rdy;
  assign bus.a_ready = a_rdy;
  assign bus.b_ready = b_rdy;
  assign bus.busy    = (state != IDLE);

  // Zero detection looks at the held operand, not at what the normalizer returns.
  assign dbl_adj = exp_adj_dbl(op_exp_hi, bus.nrm_z52, bus.nrm_op53 == 53'd0);
  assign hi_adj  = exp_adj_sgl(op_exp_hi[7:0], bus.nrm_z29, bus.nrm_op53[52:24] == 29'd0);
  assign lo_adj  = exp_adj_sgl(op_exp_lo, bus.nrm_z24, bus.nrm_op53[23:0] == 24'd0);

  // Accept stage: latch the winner and hold the normalizer inputs until the next accept
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.nrm_mode <= 1'b0;
      bus.nrm_op53 <= 53'd0;
      op_exp_hi    <= 11'd0;
      op_exp_lo    <= 8'd0;
      cnt          <= 3'd0;
      pref_b       <= 1'b0;
    end else if (acc) begin
      bus.nrm_mode <= ~grant_b;
      bus.nrm_op53 <= grant_b ? bus.b_res53 : bus.a_res53;
      op_exp_hi    <= grant_b ? {3'b000, bus.b_exp_hi} : bus.a_exp;
      op_exp_lo    <= grant_b ? bus.b_exp_lo : 8'd0;
      cnt          <= 3'(NRM_LAT);
      pref_b       <= ~grant_b;
    end else if (state == WAIT && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Capture stage: normalizer outputs plus adjusted exponents, held until handshake
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_res53  <= 53'd0;
      bus.rsp_exp_hi <= 11'd0;
      bus.rsp_exp_lo <= 8'd0;
      bus.rsp_zero   <= 2'b00;
      bus.rsp_uflow  <= 2'b00;
    end else if (cap) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_id    <= ~bus.nrm_mode;
      bus.rsp_res53 <= bus.nrm_res53;
      if (bus.nrm_mode) begin
        bus.rsp_exp_hi <= dbl_adj[10:0];
        bus.rsp_exp_lo <= 8'd0;
        bus.rsp_zero   <= {dbl_adj[12], 1'b0};
        bus.rsp_uflow  <= {dbl_adj[11], 1'b0};
      end else begin
        bus.rsp_exp_hi <= {3'b000, hi_adj[7:0]};
        bus.rsp_exp_lo <= lo_adj[7:0];
        bus.rsp_zero   <= {hi_adj[9], lo_adj[9]};
        bus.rsp_uflow  <= {hi_adj[8], lo_adj[8]};
      end
    end else if (state == RESP && bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_norm_share_ctrl.sv
// Directed bench for norm_share_ctrl: a table of single requests on a registered-normalizer
// instance, plus stall, reset-abort and arbitration sequences on two configurations.
module tb_norm_share_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests;
  int   fails;

  always #5 clk = ~clk;

  norm_share_ctrl_if ifc1 ();
  norm_share_ctrl_if ifc2 ();

  norm_share_ctrl #(.NRM_LAT(1), .RR_EN(1'b1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(ifc1.slave));
  norm_share_ctrl #(.NRM_LAT(0), .RR_EN(1'b0)) dut2 (.i_clk(clk), .i_rst(rst), .bus(ifc2.slave));

  // Reference normalizer: {z24, z29, z52, normalized mantissa(s)}
  function automatic logic [68:0] norm_f(input logic [52:0] r, input logic mode);
    logic [5:0]  z52;
    logic [4:0]  z29, z24;
    logic        f;
    logic [28:0] h;
    logic [23:0] l;
    logic [52:0] o;
    z52 = 6'd0; f = 1'b0;
    for (int i = 52; i >= 0; i--) begin
      if (!f) begin
        if (r[i]) f = 1'b1;
        else      z52 = z52 + 6'd1;
      end
    end
    z29 = 5'd0; f = 1'b0;
    for (int i = 52; i >= 24; i--) begin
      if (!f) begin
        if (r[i]) f = 1'b1;
        else      z29 = z29 + 5'd1;
      end
    end
    z24 = 5'd0; f = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!f) begin
        if (r[i]) f = 1'b1;
        else      z24 = z24 + 5'd1;
      end
    end
    h = r[52:24] << z29;
    l = r[23:0] << z24;
    o = mode ? (r << z52) : {h, l};
    norm_f = {z24, z29, z52, o};
  endfunction

  always @(posedge clk)
    {ifc1.nrm_z24, ifc1.nrm_z29, ifc1.nrm_z52, ifc1.nrm_res53} <= norm_f(ifc1.nrm_op53, ifc1.nrm_mode);

  assign {ifc2.nrm_z24, ifc2.nrm_z29, ifc2.nrm_z52, ifc2.nrm_res53} = norm_f(ifc2.nrm_op53, ifc2.nrm_mode);

  typedef struct {
    logic        is_b;
    logic [52:0] res;
    logic [10:0] ea;
    logic [7:0]  eh;
    logic [7:0]  el;
    logic [10:0] x_exph;
    logic [7:0]  x_expl;
    logic [1:0]  x_zero;
    logic [1:0]  x_uflow;
    logic [52:0] x_res;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp1(output int n);
    n = 0;
    while (!ifc1.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    @(posedge clk); #1;
    ifc1.a_res53  = v.res;
    ifc1.b_res53  = v.res;
    ifc1.a_exp    = v.ea;
    ifc1.b_exp_hi = v.eh;
    ifc1.b_exp_lo = v.el;
    ifc1.a_valid  = ~v.is_b;
    ifc1.b_valid  = v.is_b;
    #1;
    chk($sformatf("v%0d_ready", idx), {ifc1.a_ready, ifc1.b_ready}, v.is_b ? 2'b01 : 2'b10);
    @(posedge clk); #1;
    ifc1.a_valid = 1'b0;
    ifc1.b_valid = 1'b0;
    chk($sformatf("v%0d_nrm", idx), {ifc1.nrm_mode, ifc1.nrm_op53}, {~v.is_b, v.res});
    wait_rsp1(n);
    chk($sformatf("v%0d_latency", idx), n, 2);
    chk($sformatf("v%0d_id", idx), ifc1.rsp_id, v.is_b);
    chk($sformatf("v%0d_res", idx), ifc1.rsp_res53, v.x_res);
    chk($sformatf("v%0d_exp_hi", idx), ifc1.rsp_exp_hi, v.x_exph);
    chk($sformatf("v%0d_exp_lo", idx), ifc1.rsp_exp_lo, v.x_expl);
    chk($sformatf("v%0d_zero", idx), ifc1.rsp_zero, v.x_zero);
    chk($sformatf("v%0d_uflow", idx), ifc1.rsp_uflow, v.x_uflow);
    ifc1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifc1.rsp_ready = 1'b0;
    chk($sformatf("v%0d_done", idx), {ifc1.busy, ifc1.rsp_valid}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [3:0] ids1, ids2;
    int         k1, k2, first1, first2;
    logic       bseen2;

    tests = 0;
    fails = 0;
    rst   = 1'b1;
    {ifc1.a_valid, ifc1.b_valid, ifc1.rsp_ready} = 3'b110;
    {ifc2.a_valid, ifc2.b_valid, ifc2.rsp_ready} = 3'b000;
    ifc1.a_res53 = 53'd0; ifc1.b_res53 = 53'd0; ifc1.a_exp = 11'd0;
    ifc1.b_exp_hi = 8'd0; ifc1.b_exp_lo = 8'd0;
    ifc2.a_res53 = 53'd0; ifc2.b_res53 = 53'd0; ifc2.a_exp = 11'd0;
    ifc2.b_exp_hi = 8'd0; ifc2.b_exp_lo = 8'd0;

    vecs[0] = '{1'b0, 53'h1 << 40, 11'd1023, 8'd0, 8'd0, 11'd1011, 8'd0, 2'b00, 2'b00, 53'h1 << 52};
    vecs[1] = '{1'b1, (53'h1 << 50) | (53'h1 << 20), 11'd0, 8'd100, 8'd50, 11'd98, 8'd47, 2'b00, 2'b00,
                (53'h1 << 52) | (53'h1 << 23)};
    vecs[2] = '{1'b0, 53'h1 << 40, 11'd5, 8'd0, 8'd0, 11'd0, 8'd0, 2'b00, 2'b10, 53'h1 << 52};
    vecs[3] = '{1'b0, 53'h0, 11'd700, 8'd0, 8'd0, 11'd0, 8'd0, 2'b10, 2'b00, 53'h0};
    vecs[4] = '{1'b0, 53'h1 << 40, 11'd12, 8'd0, 8'd0, 11'd0, 8'd0, 2'b00, 2'b10, 53'h1 << 52};
    vecs[5] = '{1'b0, 53'h1 << 40, 11'd13, 8'd0, 8'd0, 11'd1, 8'd0, 2'b00, 2'b00, 53'h1 << 52};
    vecs[6] = '{1'b1, 53'h1 << 52, 11'd0, 8'd0, 8'd9, 11'd0, 8'd0, 2'b01, 2'b10, 53'h1 << 52};
    vecs[7] = '{1'b1, (53'h1 << 24) | 53'h1, 11'd0, 8'd200, 8'd23, 11'd172, 8'd0, 2'b00, 2'b01,
                (53'h1 << 52) | (53'h1 << 23)};
    vecs[8] = '{1'b0, {53{1'b1}}, 11'd2047, 8'd0, 8'd0, 11'd2047, 8'd0, 2'b00, 2'b00, {53{1'b1}}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {ifc1.a_ready, ifc1.b_ready, ifc1.busy, ifc1.rsp_valid, ifc1.nrm_mode}, 0);
    chk("rst_dat", {ifc1.rsp_exp_hi, ifc1.rsp_exp_lo, ifc1.rsp_zero, ifc1.rsp_uflow, ifc1.rsp_id}, 0);
    chk("rst_ops", {ifc1.nrm_op53, ifc1.rsp_res53}, 0);
    ifc1.a_valid = 1'b0;
    ifc1.b_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Response stall, then a reset while the following op is in WAIT
    @(posedge clk); #1;
    ifc1.a_res53  = 53'h1 << 40;
    ifc1.a_exp    = 11'd1023;
    ifc1.b_res53  = vecs[1].res;
    ifc1.b_exp_hi = 8'd100;
    ifc1.b_exp_lo = 8'd50;
    ifc1.b_valid  = 1'b1;
    @(posedge clk); #1;
    ifc1.a_valid = 1'b1;
    wait_rsp1(n);
    chk("stall_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ctl", {ifc1.a_ready, ifc1.b_ready, ifc1.busy, ifc1.rsp_valid, ifc1.rsp_id}, 5'b00111);
      chk("stall_dat", {ifc1.rsp_exp_hi, ifc1.rsp_exp_lo, ifc1.rsp_zero, ifc1.rsp_uflow},
          {11'd98, 8'd47, 2'b00, 2'b00});
      chk("stall_res", ifc1.rsp_res53, vecs[1].x_res);
      @(posedge clk); #1;
    end
    ifc1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifc1.rsp_ready = 1'b0;
    chk("rr_after_b", {ifc1.a_ready, ifc1.b_ready}, 2'b10);
    @(posedge clk); #1;
    chk("abort_busy", {ifc1.busy, ifc1.nrm_mode}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ctl", {ifc1.a_ready, ifc1.b_ready, ifc1.busy, ifc1.rsp_valid, ifc1.nrm_mode, ifc1.rsp_id}, 0);
    chk("abort_dat", {ifc1.rsp_exp_hi, ifc1.rsp_exp_lo, ifc1.rsp_zero, ifc1.rsp_uflow}, 0);
    chk("abort_ops", {ifc1.nrm_op53, ifc1.rsp_res53}, 0);
    @(posedge clk); #1;
    chk("abort_no_rsp", ifc1.rsp_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", {ifc1.a_ready, ifc1.b_ready}, 2'b10);
    @(posedge clk); #1;
    ifc1.a_valid = 1'b0;
    ifc1.b_valid = 1'b0;
    wait_rsp1(n);
    chk("post_rst_latency", n, 2);
    chk("post_rst_rsp", {ifc1.rsp_id, ifc1.rsp_exp_hi, ifc1.rsp_uflow}, {1'b0, 11'd1011, 2'b00});
    ifc1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifc1.rsp_ready = 1'b0;

    // Continuous contention from reset on both arbitration configurations
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ifc2.a_res53  = 53'h1 << 40;
    ifc2.a_exp    = 11'd1023;
    ifc2.b_res53  = vecs[1].res;
    ifc2.b_exp_hi = 8'd100;
    ifc2.b_exp_lo = 8'd50;
    {ifc1.a_valid, ifc1.b_valid, ifc1.rsp_ready} = 3'b111;
    {ifc2.a_valid, ifc2.b_valid, ifc2.rsp_ready} = 3'b111;
    ids1 = 4'h0; ids2 = 4'hF; k1 = 0; k2 = 0; first1 = -1; first2 = -1; bseen2 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ifc1.rsp_valid && k1 < 4) begin
        ids1[k1[1:0]] = ifc1.rsp_id;
        if (k1 == 0) first1 = c;
        k1++;
      end
      if (ifc2.rsp_valid && k2 < 4) begin
        ids2[k2[1:0]] = ifc2.rsp_id;
        if (k2 == 0) first2 = c;
        k2++;
      end
      if (ifc2.b_ready) bseen2 = 1'b1;
    end
    {ifc1.a_valid, ifc1.b_valid} = 2'b00;
    {ifc2.a_valid, ifc2.b_valid} = 2'b00;
    chk("rr1_count", k1, 4);
    chk("rr1_ids", ids1, 4'b1010);
    chk("rr1_first", first1, 3);
    chk("fp2_count", k2, 4);
    chk("fp2_ids", ids2, 4'b0000);
    chk("fp2_first", first2, 2);
    chk("fp2_no_b_ready", bseen2, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("end_idle", {ifc1.busy, ifc2.busy, ifc1.rsp_valid, ifc2.rsp_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
